overcurrent_guard: RTL and testbench

- Per-motor-channel overcurrent protection: the producing end of the ENA/ENB enable interface that the line-follower top-level controller consumes.
- Samples raw current-sense comparator outputs for H-bridge channels A and B, debounces them, and drops the matching enable on a sustained overcurrent.
- Holds the channel off for a cooldown, then retries; after MAX_RETRY trips without a healthy interval, latches the channel off until an explicit clear.

---
 rtl/overcurrent_guard.sv | 187 ++++++++++++++++++
 tb/tb_overcurrent_guard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/overcurrent_guard.sv
// Dual-channel H-bridge overcurrent guard: debounced trip, cooldown retry and
// lockout after repeated trips, producing the ENA/ENB enables.

module overcurrent_guard_ch #(
  parameter int DEBOUNCE  = 8,
  parameter int COOLDOWN  = 50000,
  parameter int MAX_RETRY = 3,
  parameter int HEALTHY   = 100000,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oc_raw,
  input  logic       clear_fault,
  output logic       en,
  output logic       trip,
  output logic       lock,
  output logic [1:0] retry
);

  localparam int DBC_W = $clog2(DEBOUNCE);
  localparam logic [DBC_W-1:0] DBC_TOP     = DBC_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] COOL_INIT   = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] HEALTHY_TOP = CNT_W'(HEALTHY - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_COOL = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] healthy_q, healthy_d;
  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             en_q, en_d;
  logic             trip_q, trip_d;
  logic             lock_q, lock_d;
  logic             oc_s;
  logic [1:0]       retry_inc;

  assign oc_s      = sync_q[1];
  assign retry_inc = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;

  always_comb begin
    sync_d    = {sync_q[0], oc_raw};
    state_d   = state_q;
    timer_d   = timer_q;
    healthy_d = healthy_q;
    dbc_d     = dbc_q;
    retry_d   = retry_q;
    trip_d    = 1'b0;
    case (state_q)
      ST_COOL: begin
        dbc_d     = '0;
        healthy_d = '0;
        if (clear_fault) retry_d = 2'd0;
        if (timer_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        // A trip on the same edge as clear_fault takes priority over the clear.
        if (oc_s && (dbc_q == DBC_TOP)) begin
          trip_d    = 1'b1;
          retry_d   = retry_inc;
          dbc_d     = '0;
          healthy_d = '0;
          if (retry_inc == RETRY_MAX) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_COOL;
            timer_d = COOL_INIT;
          end
        end else begin
          dbc_d = oc_s ? ((dbc_q == DBC_TOP) ? dbc_q : dbc_q + DBC_W'(1)) : '0;
          if (clear_fault) begin
            retry_d   = 2'd0;
            healthy_d = '0;
          end else if (oc_s || (retry_q == 2'd0)) begin
            healthy_d = '0;
          end else if (healthy_q >= HEALTHY_TOP) begin
            retry_d   = 2'd0;
            healthy_d = '0;
          end else begin
            healthy_d = healthy_q + CNT_W'(1);
          end
        end
      end
      ST_LOCK: begin
        dbc_d     = '0;
        healthy_d = '0;
        if (clear_fault) begin
          retry_d = 2'd0;
          state_d = ST_COOL;
          timer_d = COOL_INIT;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d   = ST_COOL;
        timer_d   = COOL_INIT;
        dbc_d     = '0;
        healthy_d = '0;
      end
    endcase
    en_d   = (state_d == ST_RUN);
    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COOL;
      timer_q   <= COOL_INIT;
      healthy_q <= '0;
      dbc_q     <= '0;
      retry_q   <= 2'd0;
      sync_q    <= 2'b00;
      en_q      <= 1'b0;
      trip_q    <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      healthy_q <= healthy_d;
      dbc_q     <= dbc_d;
      retry_q   <= retry_d;
      sync_q    <= sync_d;
      en_q      <= en_d;
      trip_q    <= trip_d;
      lock_q    <= lock_d;
    end
  end

  assign en    = en_q;
  assign trip  = trip_q;
  assign lock  = lock_q;
  assign retry = retry_q;

endmodule

module overcurrent_guard #(
  parameter int DEBOUNCE  = 8,
  parameter int COOLDOWN  = 50000,
  parameter int MAX_RETRY = 3,
  parameter int HEALTHY   = 100000,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oc_a,
  input  logic       oc_b,
  input  logic       clear_fault,
  output logic       ENA,
  output logic       ENB,
  output logic       trip_a,
  output logic       trip_b,
  output logic       lock_a,
  output logic       lock_b,
  output logic [1:0] retry_a,
  output logic [1:0] retry_b
);

  overcurrent_guard_ch #(
    .DEBOUNCE(DEBOUNCE), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY),
    .HEALTHY(HEALTHY), .CNT_W(CNT_W)
  ) u_ch_a (
    .clk(clk), .rst_n(rst_n), .oc_raw(oc_a), .clear_fault(clear_fault),
    .en(ENA), .trip(trip_a), .lock(lock_a), .retry(retry_a)
  );

  overcurrent_guard_ch #(
    .DEBOUNCE(DEBOUNCE), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY),
    .HEALTHY(HEALTHY), .CNT_W(CNT_W)
  ) u_ch_b (
    .clk(clk), .rst_n(rst_n), .oc_raw(oc_b), .clear_fault(clear_fault),
    .en(ENB), .trip(trip_b), .lock(lock_b), .retry(retry_b)
  );

endmodule

// File: tb/tb_overcurrent_guard.sv
// Randomized bench for overcurrent_guard against a cycle-level behavioural model
// of the protection rules, plus directed cooldown/latency/lockout/reset checks.

module tb_overcurrent_guard;

  localparam int D = 4;
  localparam int C = 10;
  localparam int M = 3;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       oc_a = 1'b0;
  logic       oc_b = 1'b0;
  logic       clear_fault = 1'b0;
  logic       ENA, ENB, trip_a, trip_b, lock_a, lock_b;
  logic [1:0] retry_a, retry_b;

  int n_checks = 0;
  int n_fail = 0;

  // model state per channel (0 = A, 1 = B)
  int m_cool[2];
  int m_streak[2];
  int m_clean[2];
  int m_retry[2];
  bit m_lock[2];
  bit m_trip[2];
  bit m_p1[2];
  bit m_p2[2];

  // random stimulus state
  int seg_left[2];
  int mode[2];
  int run_left[2];
  bit level[2];

  overcurrent_guard #(
    .DEBOUNCE(D), .COOLDOWN(C), .MAX_RETRY(M), .HEALTHY(H), .CNT_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oc_a(oc_a), .oc_b(oc_b), .clear_fault(clear_fault),
    .ENA(ENA), .ENB(ENB), .trip_a(trip_a), .trip_b(trip_b),
    .lock_a(lock_a), .lock_b(lock_b), .retry_a(retry_a), .retry_b(retry_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cool[c] = C; m_streak[c] = 0; m_clean[c] = 0; m_retry[c] = 0;
      m_lock[c] = 1'b0; m_trip[c] = 1'b0; m_p1[c] = 1'b0; m_p2[c] = 1'b0;
    end
  endtask

  // One clock edge of the protection rules for both channels.
  task automatic model_edge();
    bit raw[2];
    bit s;
    raw[0] = oc_a;
    raw[1] = oc_b;
    for (int c = 0; c < 2; c++) begin
      s = m_p2[c];
      m_p2[c] = m_p1[c];
      m_p1[c] = raw[c];
      m_trip[c] = 1'b0;
      if (m_lock[c]) begin
        m_streak[c] = 0; m_clean[c] = 0;
        if (clear_fault) begin
          m_lock[c] = 1'b0; m_retry[c] = 0; m_cool[c] = C;
        end
      end else if (m_cool[c] > 0) begin
        m_cool[c]--; m_streak[c] = 0; m_clean[c] = 0;
        if (clear_fault) m_retry[c] = 0;
      end else begin
        m_streak[c] = s ? m_streak[c] + 1 : 0;
        if (m_streak[c] == D) begin
          m_trip[c] = 1'b1; m_retry[c]++; m_streak[c] = 0; m_clean[c] = 0;
          if (m_retry[c] == M) m_lock[c] = 1'b1;
          else m_cool[c] = C;
        end else if (clear_fault) begin
          m_retry[c] = 0; m_clean[c] = 0;
        end else if (s || m_retry[c] == 0) begin
          m_clean[c] = 0;
        end else begin
          m_clean[c]++;
          if (m_clean[c] == H) begin
            m_retry[c] = 0; m_clean[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ENA", int'(ENA), int'(!m_lock[0] && m_cool[0] == 0));
    check_eq("ENB", int'(ENB), int'(!m_lock[1] && m_cool[1] == 0));
    check_eq("trip_a", int'(trip_a), int'(m_trip[0]));
    check_eq("trip_b", int'(trip_b), int'(m_trip[1]));
    check_eq("lock_a", int'(lock_a), int'(m_lock[0]));
    check_eq("lock_b", int'(lock_b), int'(m_lock[1]));
    check_eq("retry_a", int'(retry_a), m_retry[0]);
    check_eq("retry_b", int'(retry_b), m_retry[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_until_en(input string tag, input int exp);
    int n;
    n = 0;
    while (ENA !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, n, exp);
  endtask

  task automatic run_until_lock(input int budget);
    int n;
    n = 0;
    while (lock_a !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq("lock_reached", int'(lock_a), 1);
    check_eq("lock_retry", int'(retry_a), M);
  endtask

  task automatic drive_random();
    bit v[2];
    for (int c = 0; c < 2; c++) begin
      if (seg_left[c] == 0) begin
        mode[c] = $urandom_range(0, 3);
        seg_left[c] = $urandom_range(10, 60);
      end
      seg_left[c]--;
      case (mode[c])
        0: v[c] = 1'b0;
        1: begin
          if (run_left[c] == 0) begin
            level[c] = ~level[c];
            run_left[c] = level[c] ? $urandom_range(1, D - 1) : $urandom_range(1, 6);
          end
          run_left[c]--;
          v[c] = level[c];
        end
        2: v[c] = 1'b1;
        default: v[c] = 1'($urandom_range(0, 1));
      endcase
    end
    oc_a = v[0];
    oc_b = v[1];
    clear_fault = ($urandom_range(0, 59) == 0);
    // steer some clears onto the exact edge channel A is about to trip
    if (!m_lock[0] && m_cool[0] == 0 && m_p2[0] && m_streak[0] == D - 1 &&
        $urandom_range(0, 1) == 1)
      clear_fault = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      seg_left[c] = 0; mode[c] = 0; run_left[c] = 0; level[c] = 1'b0;
    end

    // reset state and first cooldown
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    count_until_en("cooldown_after_reset", C);

    // short pulse must not trip
    oc_a = 1'b1;
    repeat (D - 1) tick();
    oc_a = 1'b0;
    repeat (10) tick();

    // sustained overcurrent: enable falls D+2 edges after the rise
    oc_a = 1'b1;
    n = 0;
    while (ENA === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq("trip_latency", n, D + 2);
    check_eq("enb_unaffected", int'(ENB), 1);

    // repeated trips lead to lockout, clear releases after a full cooldown
    run_until_lock(200);
    oc_a = 1'b0;
    repeat (30) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    count_until_en("cooldown_after_clear", C);

    // reset mid-LOCK, then mid-COOL
    oc_a = 1'b1;
    run_until_lock(200);
    oc_a = 1'b0;
    repeat (3) tick();
    do_reset();
    count_until_en("cooldown_after_lock_reset", C);
    oc_a = 1'b1;
    repeat (D + 3) tick();
    oc_a = 1'b0;
    repeat (4) tick();
    do_reset();
    count_until_en("cooldown_after_cool_reset", C);

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 6000; i++) begin
      drive_random();
      if ($urandom_range(0, 1499) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
